apb_completer_regfile: RTL and testbench
========================================

// Module: apb_completer_regfile
// PURPOSE
//  APB4 completer: the far end of the team's APB requester. Decodes one aligned-word register bank
//  of NUM_REGS entries, accepts byte-strobed writes, returns read data and pslverr.
//  Sits behind the interconnect and exposes the bank flat to local logic plus per-register write pulses.
// PARAMETERS
//  ADDR_WIDTH   32  paddr width
//  DATA_WIDTH   32  data width; multiple of 8; BYTES = DATA_WIDTH/8, AL = $clog2(BYTES)
//  NUM_REGS     8   register count, >=2; IW = $clog2(NUM_REGS)
//  WAIT_CYCLES  2   access-phase wait states (APB_COMPLETER_WAIT_EN only), 0..15
// PORTS
//  pclk      in   1                  APB clock
//  presetn   in   1                  async active-low reset
//  paddr     in   ADDR_WIDTH         byte address
//  pprot     in   3                  ignored
//  pnse      in   1                  ignored
//  psel      in   1                  select
//  penable   in   1                  access phase
//  pwrite    in   1                  1=write
//  pwdata    in   DATA_WIDTH         write data
//  pstrb     in   BYTES              byte write strobes
//  pready    out  1                  transfer complete
//  prdata    out  DATA_WIDTH         read data, valid while pready
//  pslverr   out  1                  error, valid while pready
//  reg_q     out  NUM_REGS*DATA_WIDTH register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//  wr_pulse  out  NUM_REGS           1-cycle pulse, cycle after a committed write to reg i
// BEHAVIOUR
//  Reset (presetn async, active-low; clock pclk): state=IDLE, wait cnt=0, all regs=0, prdata=0, pslverr=0, wr_pulse=0; pready=0.
//  Decode: idx=paddr[AL+:IW]; err_d=1 if paddr[AL-1:0]!=0, or idx>=NUM_REGS, or paddr above bit AL+IW-1 nonzero.
//  FSM IDLE->ACCESS on edge with psel&~penable (setup): register err_d->pslverr; read: prdata<=err_d?0:reg[idx];
//    write: prdata<=0; cnt<=WAIT_CYCLES (0 without macro).
//  ACCESS: cnt decrements by 1 per cycle while psel&penable&cnt!=0.
//  pready = (state==ACCESS)&psel&penable&(cnt==0), combinational from registered state; 0 in IDLE.
//  Completion edge (pready=1): state->IDLE, prdata<=0, pslverr<=0. Write & ~pslverr: byte b of reg[idx]
//    <= pwdata byte b where pstrb[b]; wr_pulse[idx]=1 next cycle even if pstrb==0. Error write: no change, no pulse.
//  Read ignores pstrb. Address/control sampled at setup edge; paddr changes in access phase are ignored.
//  Latency: 0 wait states without macro (setup+access = 2 cycles); WAIT_CYCLES extra with macro.
//  Back-to-back: next setup one cycle after completion is accepted normally; no dead cycle.
//  Protocol abort: psel=0 while ACCESS -> state->IDLE, no write, prdata/pslverr cleared, no pulse.
//  Reset mid-transfer: everything returns to reset values immediately; pending write dropped.
//  Register writes occur only at completion edges; reg_q reflects them the following cycle.
// CONFIGURATION
//  APB_COMPLETER_WAIT_EN defined: wait counter built, loaded with WAIT_CYCLES per transfer.
//  Undefined: no counter logic, cnt tied 0, WAIT_CYCLES unused, pready high on first access cycle.
// TESTING
//  Write 0xA5A5_1234 to 0x04 with pstrb=0xF, no macro -> pready=1 in the access cycle, pslverr=0;
//    reg_q[1] =0xA5A5_1234; wr_pulse=0b0000_0010 for 1 cycle.
//  Partial write pstrb=0b0101 data 0xFFFF_FFFF to 0x04 -> reg1=0xA5FF_12FF; read 0x04 -> prdata=0xA5FF_12FF.
//  Read 0x20 (idx 8) and 0x06 (misaligned) -> pslverr=1 and prdata=0 with pready; regs unchanged; no pulse.
//  Macro on, WAIT_CYCLES=2 -> pready low for 2 access cycles, high on the 3rd; then back-to-back read returns the correct data.
//  presetn low during the access phase of a write to 0x08 -> reg2 stays 0, pready=0, wr_pulse=0.
//  psel dropped mid-access (macro on) -> FSM back to IDLE, no write; next transfer completes normally.

Source files
------------

// File: rtl/apb_completer_regfile.sv
// APB4 completer: flat bank of NUM_REGS word registers, byte-strobed writes, per-register write pulses.
// Latency: setup + 1 access cycle; APB_COMPLETER_WAIT_EN adds WAIT_CYCLES access wait states.
// Backpressure: pready held low while wait states run; psel dropped in access aborts without a write.
module apb_completer_regfile #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                           pclk,
   input  logic                           presetn,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic [2:0]                     pprot,
   input  logic                           pnse,
   input  logic                           psel,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [DATA_WIDTH-1:0]          pwdata,
   input  logic [DATA_WIDTH/8-1:0]        pstrb,
   output logic                           pready,
   output logic [DATA_WIDTH-1:0]          prdata,
   output logic                           pslverr,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int AL    = $clog2(BYTES);
   localparam int IW    = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << AL) - 64'd1);
   localparam logic [IW:0]           NREGS      = (IW + 1)'(NUM_REGS);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                             state_q, state_d;
   logic [IW-1:0]                      idx_q, idx_d;
   logic                               write_q, write_d;
   logic                               pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0]              prdata_q, prdata_d;
   logic [NUM_REGS-1:0]                wr_pulse_q, wr_pulse_d;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

   logic [IW-1:0] addr_idx;
   logic          addr_err;
   logic          cnt_zero;
   logic          unused_ok;

`ifdef APB_COMPLETER_WAIT_EN
   logic [3:0] cnt_q, cnt_d;

   // Wait-state counter register.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) cnt_q <= 4'd0;
      else          cnt_q <= cnt_d;
   end

   assign cnt_zero  = (cnt_q == 4'd0);
   assign unused_ok = ^{pprot, pnse};
`else
   assign cnt_zero  = 1'b1;
   assign unused_ok = ^{pprot, pnse, WAIT_CYCLES};
`endif

   // Address decode: word index plus misaligned / out-of-bank detection.
   always_comb begin
      addr_idx = paddr[AL +: IW];
      addr_err = (|(paddr & ALIGN_MASK)) |
                 ({1'b0, addr_idx} >= NREGS) |
                 (|(paddr >> (AL + IW)));
   end

   assign pready = (state_q == ACCESS) && psel && penable && cnt_zero;

   // Transfer FSM: capture at setup, count waits, commit or abort in access.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      write_d    = write_q;
      pslverr_d  = pslverr_q;
      prdata_d   = prdata_q;
      wr_pulse_d = '0;
      regs_d     = regs_q;
`ifdef APB_COMPLETER_WAIT_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d   = ACCESS;
               idx_d     = addr_idx;
               write_d   = pwrite;
               pslverr_d = addr_err;
               prdata_d  = (pwrite || addr_err) ? '0 : regs_q[addr_idx];
`ifdef APB_COMPLETER_WAIT_EN
               cnt_d     = WAIT_CYCLES[3:0];
`endif
            end
         end
         ACCESS: begin
            if (!psel) begin
               // Requester abandoned the transfer: drop it without side effects.
               state_d   = IDLE;
               prdata_d  = '0;
               pslverr_d = 1'b0;
`ifdef APB_COMPLETER_WAIT_EN
               cnt_d     = 4'd0;
`endif
            end else if (pready) begin
               state_d   = IDLE;
               prdata_d  = '0;
               pslverr_d = 1'b0;
               if (write_q && !pslverr_q) begin
                  for (int b = 0; b < BYTES; b++) begin
                     if (pstrb[b]) regs_d[idx_q][b*8 +: 8] = pwdata[b*8 +: 8];
                  end
                  // Pulse even for an all-zero strobe: the write still happened on the bus.
                  wr_pulse_d[idx_q] = 1'b1;
               end
            end else begin
`ifdef APB_COMPLETER_WAIT_EN
               if (penable && !cnt_zero) cnt_d = cnt_q - 4'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, capture and register-bank flops.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         write_q    <= 1'b0;
         pslverr_q  <= 1'b0;
         prdata_q   <= '0;
         wr_pulse_q <= '0;
         regs_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         write_q    <= write_d;
         pslverr_q  <= pslverr_d;
         prdata_q   <= prdata_d;
         wr_pulse_q <= wr_pulse_d;
         regs_q     <= regs_d;
      end
   end

   assign prdata   = prdata_q;
   assign pslverr  = pslverr_q;
   assign wr_pulse = wr_pulse_q;
   assign reg_q    = regs_q;

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Bench for apb_completer_regfile: vector table of APB transfers plus abort and reset corner cases.
// Expected wait states follow APB_COMPLETER_WAIT_EN (WAIT_CYCLES=2 when defined, else 0).
// Inputs driven #1 after the rising edge; outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_apb_completer_regfile;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam int WC = 2;
`ifdef APB_COMPLETER_WAIT_EN
   localparam int EXP_WAITS = WC;
`else
   localparam int EXP_WAITS = 0;
`endif

   logic             pclk = 1'b0;
   logic             presetn;
   logic [AW-1:0]    paddr;
   logic [2:0]       pprot;
   logic             pnse;
   logic             psel;
   logic             penable;
   logic             pwrite;
   logic [DW-1:0]    pwdata;
   logic [DW/8-1:0]  pstrb;
   logic             pready;
   logic [DW-1:0]    prdata;
   logic             pslverr;
   logic [NR*DW-1:0] reg_q;
   logic [NR-1:0]    wr_pulse;

   apb_completer_regfile #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_CYCLES(WC)
   ) dut (
      .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot), .pnse(pnse),
      .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready), .prdata(prdata), .pslverr(pslverr), .reg_q(reg_q), .wr_pulse(wr_pulse)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      bit          exp_err;
      logic [7:0]  exp_pulse;
      logic [31:0] exp_reg;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
      logic [7:0]  pulse;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[17];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // One complete transfer starting in the current cycle (called just after a rising edge).
   task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input exp_t e);
      int   waits;
      exp_t got;
      exp_q.push_back(e);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge pclk); #1;
      penable = 1'b1;
      paddr   = ~addr;
      waits   = 0;
      forever begin
         @(negedge pclk);
         if (pready) break;
         waits++;
         if (waits > 40) break;
      end
      check({tag, "_waits"}, waits, EXP_WAITS);
      got = exp_q.pop_front();
      check({tag, "_pslverr"}, pslverr, got.err);
      check({tag, "_prdata"}, prdata, got.rdata);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      check({tag, "_wr_pulse"}, wr_pulse, got.pulse);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b1, 32'h04,       32'hA5A51234, 4'hF, 32'h0,        1'b0, 8'h02, 32'hA5A51234};
      vecs[1]  = '{1'b0, 32'h04,       32'h0,        4'h0, 32'hA5A51234, 1'b0, 8'h00, 32'h0};
      vecs[2]  = '{1'b1, 32'h04,       32'hFFFFFFFF, 4'h5, 32'h0,        1'b0, 8'h02, 32'hA5FF12FF};
      vecs[3]  = '{1'b0, 32'h04,       32'h0,        4'h0, 32'hA5FF12FF, 1'b0, 8'h00, 32'h0};
      vecs[4]  = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h0,        1'b1, 8'h00, 32'h0};
      vecs[5]  = '{1'b0, 32'h06,       32'h0,        4'h0, 32'h0,        1'b1, 8'h00, 32'h0};
      vecs[6]  = '{1'b1, 32'h20,       32'hDEADBEEF, 4'hF, 32'h0,        1'b1, 8'h00, 32'h0};
      vecs[7]  = '{1'b1, 32'h07,       32'hDEADBEEF, 4'hF, 32'h0,        1'b1, 8'h00, 32'h0};
      vecs[8]  = '{1'b1, 32'h1C,       32'h11223344, 4'hF, 32'h0,        1'b0, 8'h80, 32'h11223344};
      vecs[9]  = '{1'b1, 32'h00,       32'hCAFEF00D, 4'h0, 32'h0,        1'b0, 8'h01, 32'h0};
      vecs[10] = '{1'b0, 32'h00,       32'h0,        4'hF, 32'h0,        1'b0, 8'h00, 32'h0};
      vecs[11] = '{1'b0, 32'h1C,       32'h0,        4'h0, 32'h11223344, 1'b0, 8'h00, 32'h0};
      vecs[12] = '{1'b1, 32'h100,      32'hDEADBEEF, 4'hF, 32'h0,        1'b1, 8'h00, 32'h0};
      vecs[13] = '{1'b0, 32'h10000004, 32'h0,        4'h0, 32'h0,        1'b1, 8'h00, 32'h0};
      vecs[14] = '{1'b1, 32'h08,       32'h0000ABCD, 4'h3, 32'h0,        1'b0, 8'h04, 32'h0000ABCD};
      vecs[15] = '{1'b0, 32'h08,       32'h0,        4'h0, 32'h0000ABCD, 1'b0, 8'h00, 32'h0};
      vecs[16] = '{1'b0, 32'h04,       32'h0,        4'h0, 32'hA5FF12FF, 1'b0, 8'h00, 32'h0};

      presetn = 1'b0; paddr = '0; pprot = 3'b0; pnse = 1'b0;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; pwdata = '0; pstrb = '0;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      check("rst_pready", pready, 1'b0);
      check("rst_prdata", prdata, 32'h0);
      check("rst_pslverr", pslverr, 1'b0);
      check("rst_wr_pulse", wr_pulse, 8'h0);
      check("rst_reg_q", reg_q, 256'h0);
      psel = 1'b0; penable = 1'b0;
      presetn = 1'b1;
      @(posedge pclk); #1;

      // Table runs back-to-back: each setup directly follows the previous completion.
      for (int i = 0; i < 17; i++) begin
         xfer($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
              '{vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_pulse});
         if (vecs[i].wr && !vecs[i].exp_err)
            check($sformatf("v%0d_reg", i), reg_q[vecs[i].addr[4:2]*32 +: 32], vecs[i].exp_reg);
      end
      check("table_reg_q", reg_q, {32'h11223344, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h0000ABCD, 32'hA5FF12FF, 32'h0});

      // Abort straight after setup: no write, no pulse.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h12345678; pstrb = 4'hF;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("abort_pready", pready, 1'b0);
      @(posedge pclk); #1;
      check("abort_wr_pulse", wr_pulse, 8'h0);
      check("abort_reg3", reg_q[96 +: 32], 32'h0);
`ifdef APB_COMPLETER_WAIT_EN
      // Abort during an access wait state.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h87654321; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      check("wabort_pready", pready, 1'b0);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      check("wabort_wr_pulse", wr_pulse, 8'h0);
      check("wabort_reg3", reg_q[96 +: 32], 32'h0);
`endif
      xfer("post_abort_rd", 1'b0, 32'h0C, 32'h0, 4'h0, '{32'h0, 1'b0, 8'h00});
      xfer("reg3_wr", 1'b1, 32'h0C, 32'h0BADF00D, 4'hF, '{32'h0, 1'b0, 8'h08});
      @(posedge pclk); #1;
      check("pulse_one_cycle", wr_pulse, 8'h0);
      xfer("reg3_rd", 1'b0, 32'h0C, 32'h0, 4'h0, '{32'h0BADF00D, 1'b0, 8'h00});

      // Reset asserted in the access phase of a write to reg2.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h55555555; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      presetn = 1'b0;
      #1;
      check("rstmid_pready", pready, 1'b0);
      check("rstmid_prdata", prdata, 32'h0);
      check("rstmid_pslverr", pslverr, 1'b0);
      @(posedge pclk); #1;
      check("rstmid_reg2", reg_q[64 +: 32], 32'h0);
      check("rstmid_wr_pulse", wr_pulse, 8'h0);
      check("rstmid_reg_q", reg_q, 256'h0);
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
      @(posedge pclk); #1;
      check("rstmid_wr_pulse_after", wr_pulse, 8'h0);
      xfer("post_rst_rd2", 1'b0, 32'h08, 32'h0, 4'h0, '{32'h0, 1'b0, 8'h00});
      xfer("post_rst_wr5", 1'b1, 32'h14, 32'h00C0FFEE, 4'hF, '{32'h0, 1'b0, 8'h20});
      xfer("post_rst_rd5", 1'b0, 32'h14, 32'h0, 4'h0, '{32'h00C0FFEE, 1'b0, 8'h00});

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
